// File: rtl/adc_capture_pkg.sv
// Shared types and sizing helpers for the triggered burst-capture controller.
package adc_capture_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/adc_capture_buf.sv
// Sample buffer: DEPTH x DATA_W simple dual-port RAM, synchronous write,
// registered read with one cycle of latency.
module adc_capture_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Same-address collision returns the new word; a 1-sample burst enters
  // DRAIN on the very edge that writes address 0.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= (we && (waddr == raddr)) ? wdata : mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered burst-capture sequencer: decimate, wait for a rising level
// crossing, capture a burst, drain it over valid/ready.
// Optional: ADC_CAPTURE_AUTO_REARM_EN re-enters WAIT_TRIG after each burst.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 64,
  parameter int DECIM_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    adc_in,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [DECIM_W-1:0]   decim,
  input  logic [DATA_W-1:0]    trig_level,
  input  logic [$clog2(DEPTH):0] burst_len,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t              state_q, state_d;
  logic [DECIM_W-1:0]  dcnt_q, dcnt_d, decim_q, decim_d;
  logic [DATA_W-1:0]   trig_q, trig_d, prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [LW-1:0]       len_q, len_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;

  logic                strobe, trig_hit, we;
  logic [PW-1:0]       waddr, raddr;
  logic [DATA_W-1:0]   rdata;

  adc_capture_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PW(PW)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (adc_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    decim_d      = decim_q;
    trig_d       = trig_q;
    len_d        = len_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    we           = 1'b0;
    waddr        = '0;

    strobe   = (dcnt_q == '0);
    trig_hit = strobe && prev_valid_q &&
               ($signed(prev_q) < $signed(trig_q)) &&
               ($signed(adc_in) >= $signed(trig_q));

    if (state_q == WAIT_TRIG || state_q == CAPTURE)
      dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (arm) begin
          decim_d      = decim;
          trig_d       = trig_level;
          len_d        = (burst_len == '0 || burst_len > DEPTH_L) ? DEPTH_L : burst_len;
          dcnt_d       = '0;
          prev_valid_d = 1'b0;
          state_d      = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (strobe) begin
          prev_d       = adc_in;
          prev_valid_d = 1'b1;
        end
        if (trig_hit) begin
          we       = 1'b1;
          wr_ptr_d = LW'(1);
          if (len_q == LW'(1)) begin
            rd_ptr_d = '0;
            state_d  = DRAIN;
          end else begin
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (strobe) begin
          we       = 1'b1;
          waddr    = wr_ptr_q[PW-1:0];
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_d == len_q) begin
            rd_ptr_d = '0;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        // rdata always holds the word at rd_ptr_q, ready to load on a free slot.
        if (rd_ptr_q != len_q && (!out_valid_q || out_ready)) begin
          out_data_d  = rdata;
          out_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
`ifdef ADC_CAPTURE_AUTO_REARM_EN
          state_d      = WAIT_TRIG;
          dcnt_d       = '0;
          prev_valid_d = 1'b0;
`else
          state_d      = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      we          = 1'b0;
    end

    busy_d = (state_d != IDLE);
    raddr  = rd_ptr_d[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dcnt_q       <= '0;
      decim_q      <= '0;
      trig_q       <= '0;
      len_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      decim_q      <= decim_d;
      trig_q       <= trig_d;
      len_q        <= len_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
